// File: rtl/ib_mul_acc.sv
// Accumulates a run of unsigned 16-bit products into a saturating ACC_W-bit sum.
// The run length is latched at start; the result is held until the downstream handshake.
module ib_mul_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic [15:0]      i_c,
  input  logic             i_c_valid,
  output logic             o_c_ready,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  // One extra bit so a zero length field can be held as 2^CNT_W.
  logic [CNT_W:0]   cnt;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             last;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s, input logic ovf_in);
    return (s[ACC_W] || ovf_in) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W:0] run_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
  endfunction

  assign accept = (state == ACC) && i_c_valid;
  assign last   = (cnt == {{CNT_W{1'b0}}, 1'b1});
  assign sum    = {1'b0, o_acc} + (ACC_W+1)'(i_c);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ACC;
      ACC:     if (accept && last) state_nxt = DONE;
      DONE:    if (i_acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_c_ready   = (state == ACC);
    o_acc_valid = (state == DONE);
    o_busy      = (state != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (state == IDLE && i_start) begin
      cnt   <= run_len(i_len);
      o_acc <= '0;
      o_ovf <= 1'b0;
    end else if (accept) begin
      cnt   <= cnt - 1'b1;
      o_acc <= sat_acc(sum, o_ovf);
      o_ovf <= o_ovf | sum[ACC_W];
    end
  end

endmodule

// File: doc/ib_mul_acc.md
IB_MUL_ACC -- requirements
Module: ib_mul_acc

Interface
REQ-001 Parameter ACC_W, default 24, accumulator and result width in bits; legal range 17..32.
REQ-002 Parameter CNT_W, default 8, length-field width in bits.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  single-cycle request to begin an accumulation run.
REQ-006 i_len  input  CNT_W  number of products in the run; value 0 means 2^CNT_W.
REQ-007 i_c  input  16  unsigned product from the upstream 8x8 multiplier.
REQ-008 i_c_valid  input  1  i_c is valid this cycle.
REQ-009 o_c_ready  output  1  block accepts i_c this cycle.
REQ-010 o_acc  output  ACC_W  accumulated sum of the run.
REQ-011 o_acc_valid  output  1  o_acc holds a completed result.
REQ-012 i_acc_ready  input  1  downstream consumes o_acc this cycle.
REQ-013 o_ovf  output  1  the current or last run saturated.
REQ-014 o_busy  output  1  state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-016 IDLE: when i_start=1, the block SHALL latch i_len into the remaining count, clear o_acc to 0, clear o_ovf, and enter ACC on the next edge.
REQ-017 i_start SHALL be ignored in ACC and DONE.
REQ-018 The block SHALL assert o_c_ready only in ACC, driven combinationally from state.
REQ-019 A product SHALL be accepted on an edge where i_c_valid=1 and o_c_ready=1; i_c_valid outside ACC SHALL have no effect.
REQ-020 On acceptance, o_acc SHALL become o_acc + zero-extended i_c, computed at ACC_W+1 bits.
REQ-021 Saturation: if the sum's bit ACC_W is set, or o_ovf is already 1, o_acc SHALL become all ones and o_ovf SHALL be set, remaining set until the next accepted i_start or reset.
REQ-022 The remaining count SHALL decrement by one per accepted product.
REQ-023 When the final product of the run is accepted, the state SHALL move to DONE on the same edge.
REQ-024 o_acc_valid SHALL be 1 exactly while in DONE, one cycle after the final acceptance.
REQ-025 In DONE, o_acc and o_ovf SHALL be held stable.
REQ-026 DONE SHALL move to IDLE on the first edge with i_acc_ready=1; o_acc SHALL retain its value in IDLE.
REQ-027 Cycles with i_c_valid=0 in ACC SHALL leave o_acc and the count unchanged; gaps of any length are legal.
REQ-028 Minimum run time SHALL be: 1 cycle (start) + N accept cycles + 1 handshake cycle. Back-to-back runs SHALL be possible with i_start asserted in the IDLE cycle that follows the handshake.
REQ-029 i_len = 0 SHALL run exactly 2^CNT_W products; the counter SHALL NOT wrap early.

Reset
REQ-030 When i_rst is asserted, immediately and without waiting for a clock edge, the block SHALL go to IDLE with o_acc=0, o_ovf=0, the count at 0, o_acc_valid=0, o_c_ready=0 and o_busy=0.
REQ-031 Reset asserted mid-run SHALL abandon the run; no partial result SHALL be presented after reset deasserts.

Verification
REQ-032 Run with i_len=3 and products 65025, 1, 2 with no gaps: o_acc_valid rises 1 cycle after the third accept, o_acc=65028, o_ovf=0.
REQ-033 Run with ACC_W=18, i_len=5 and every product 65535: the fifth add exceeds 262143, so o_acc=262143 and o_ovf=1 at DONE.
REQ-034 Backpressure: hold i_acc_ready=0 for 10 cycles in DONE: o_acc_valid stays 1 and o_acc stays stable; i_start pulses during DONE are ignored; IDLE follows the ready edge.
REQ-035 Gaps: i_len=4 with i_c_valid toggling 1,0,0,1,1,0,1 and products 10,20,30,40 on the valid cycles: o_acc=100.
REQ-036 Reset after 2 of i_len=4 products: all outputs read 0 at once; a new run with i_len=1 and product 7 gives o_acc=7.
REQ-037 i_len=0 with CNT_W=8 and product 1: exactly 256 accepts occur, then o_acc=256 and o_acc_valid=1.
